// File: rtl/picorv32_mem_arbiter.sv
// Two-master arbiter for a picorv32-native memory port with a registered grant held until handshake.
// Also flags downstream stalls that run too long and owners that withdraw a request early.
module picorv32_mem_arbiter #(
   parameter int MAX_WAIT   = 16,
   parameter bit PRIO_FIXED = 1'b0
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        p0_valid,
   input  logic        p0_instr,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic [3:0]  p0_wstrb,
   output logic        p0_ready,
   output logic [31:0] p0_rdata,

   input  logic        p1_valid,
   input  logic        p1_instr,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   input  logic [3:0]  p1_wstrb,
   output logic        p1_ready,
   output logic [31:0] p1_rdata,

   output logic        mem_valid,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,

   output logic [1:0]  owner,
   output logic        timeout,
   output logic        proto_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

   state_t     state, state_next;
   logic       last_grant, last_grant_next;
   logic [7:0] wait_cnt, wait_cnt_next;
   logic       timeout_q, timeout_next;
   logic       proto_err_q, proto_err_next;

   logic       sel_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         wait_cnt    <= 8'd0;
         timeout_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state       <= state_next;
         last_grant  <= last_grant_next;
         wait_cnt    <= wait_cnt_next;
         timeout_q   <= timeout_next;
         proto_err_q <= proto_err_next;
      end
   end

   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      wait_cnt_next   = wait_cnt;
      timeout_next    = timeout_q;
      proto_err_next  = proto_err_q;
      sel_valid       = 1'b0;
      mem_valid       = 1'b0;
      mem_instr       = 1'b0;
      mem_addr        = 32'd0;
      mem_wdata       = 32'd0;
      mem_wstrb       = 4'd0;
      p0_ready        = 1'b0;
      p1_ready        = 1'b0;
      p0_rdata        = 32'd0;
      p1_rdata        = 32'd0;

      case (state)
         IDLE: begin
            wait_cnt_next = 8'd0;
            // last_grant==1 means p1 went last, so p0 is next in round-robin
            if (p0_valid && p1_valid)
               state_next = (PRIO_FIXED || last_grant) ? OWN0 : OWN1;
            else if (p0_valid)
               state_next = OWN0;
            else if (p1_valid)
               state_next = OWN1;
         end
         OWN0: begin
            sel_valid = p0_valid;
            mem_valid = p0_valid;
            mem_instr = p0_instr;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
            mem_wstrb = p0_wstrb;
            p0_ready  = mem_ready && p0_valid;
            p0_rdata  = mem_rdata;
         end
         OWN1: begin
            sel_valid = p1_valid;
            mem_valid = p1_valid;
            mem_instr = p1_instr;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            mem_wstrb = p1_wstrb;
            p1_ready  = mem_ready && p1_valid;
            p1_rdata  = mem_rdata;
         end
         default: state_next = IDLE;
      endcase

      // Shared ownership bookkeeping: withdrawal, completion, or another stall cycle
      if (state == OWN0 || state == OWN1) begin
         if (!sel_valid) begin
            proto_err_next = 1'b1;
            state_next     = IDLE;
            wait_cnt_next  = 8'd0;
         end else if (mem_ready) begin
            last_grant_next = (state == OWN1);
            state_next      = IDLE;
            wait_cnt_next   = 8'd0;
         end else if (wait_cnt < MAX_W8) begin
            wait_cnt_next = wait_cnt + 8'd1;
            if (wait_cnt + 8'd1 == MAX_W8)
               timeout_next = 1'b1;
         end
      end

      // The reset cycle itself must not leak a request or a completion
      if (reset) begin
         mem_valid = 1'b0;
         mem_instr = 1'b0;
         mem_addr  = 32'd0;
         mem_wdata = 32'd0;
         mem_wstrb = 4'd0;
         p0_ready  = 1'b0;
         p1_ready  = 1'b0;
         p0_rdata  = 32'd0;
         p1_rdata  = 32'd0;
      end
   end

   assign owner     = reset ? 2'd0 : state;
   assign timeout   = timeout_q && !reset;
   assign proto_err = proto_err_q && !reset;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Directed bench: a per-cycle vector table on a round-robin instance (MAX_WAIT=4),
// plus a hand sequence comparing it against a fixed-priority instance under constant contention.
module tb_picorv32_mem_arbiter;

   localparam logic [31:0] P0_ADDR  = 32'h0000_0100;
   localparam logic [31:0] P0_WDATA = 32'hA0A0_A0A0;
   localparam logic [3:0]  P0_WSTRB = 4'h0;
   localparam logic [31:0] P1_ADDR  = 32'h0000_0200;
   localparam logic [31:0] P1_WDATA = 32'h1234_5678;
   localparam logic [3:0]  P1_WSTRB = 4'hF;

   logic        clk = 1'b0;
   logic        reset;
   logic        p0_valid, p0_instr, p1_valid, p1_instr;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic [3:0]  p0_wstrb, p1_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   logic        p0_ready, p1_ready, mem_valid, mem_instr, timeout, proto_err;
   logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [1:0]  owner;

   logic        fx_p0_ready, fx_p1_ready, fx_mem_valid, fx_mem_instr, fx_timeout, fx_proto_err;
   logic [31:0] fx_p0_rdata, fx_p1_rdata, fx_mem_addr, fx_mem_wdata;
   logic [3:0]  fx_mem_wstrb;
   logic [1:0]  fx_owner;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   picorv32_mem_arbiter #(.MAX_WAIT(4), .PRIO_FIXED(1'b0)) dut (
      .clk(clk), .reset(reset),
      .p0_valid(p0_valid), .p0_instr(p0_instr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_wstrb(p0_wstrb), .p0_ready(p0_ready), .p0_rdata(p0_rdata),
      .p1_valid(p1_valid), .p1_instr(p1_instr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_wstrb(p1_wstrb), .p1_ready(p1_ready), .p1_rdata(p1_rdata),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .owner(owner), .timeout(timeout), .proto_err(proto_err)
   );

   picorv32_mem_arbiter #(.MAX_WAIT(16), .PRIO_FIXED(1'b1)) dut_fx (
      .clk(clk), .reset(reset),
      .p0_valid(p0_valid), .p0_instr(p0_instr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_wstrb(p0_wstrb), .p0_ready(fx_p0_ready), .p0_rdata(fx_p0_rdata),
      .p1_valid(p1_valid), .p1_instr(p1_instr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_wstrb(p1_wstrb), .p1_ready(fx_p1_ready), .p1_rdata(fx_p1_rdata),
      .mem_valid(fx_mem_valid), .mem_instr(fx_mem_instr), .mem_addr(fx_mem_addr),
      .mem_wdata(fx_mem_wdata), .mem_wstrb(fx_mem_wstrb), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .owner(fx_owner), .timeout(fx_timeout), .proto_err(fx_proto_err)
   );

   typedef struct {
      logic        rst;
      logic        v0;
      logic        v1;
      logic        rdy;
      logic [31:0] rdata;
      logic        e_mvalid;
      logic [31:0] e_maddr;
      logic [3:0]  e_mwstrb;
      logic        e_r0;
      logic        e_r1;
      logic [31:0] e_rd0;
      logic [31:0] e_rd1;
      logic [1:0]  e_owner;
      logic        e_to;
      logic        e_pe;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic v0, input logic v1, input logic rdy,
                               input logic [31:0] rdata, input logic mv, input logic [31:0] maddr,
                               input logic [3:0] mws, input logic r0, input logic r1,
                               input logic [31:0] rd0, input logic [31:0] rd1,
                               input logic [1:0] own, input logic to, input logic pe);
      vec_t v;
      v.rst = rst; v.v0 = v0; v.v1 = v1; v.rdy = rdy; v.rdata = rdata;
      v.e_mvalid = mv; v.e_maddr = maddr; v.e_mwstrb = mws;
      v.e_r0 = r0; v.e_r1 = r1; v.e_rd0 = rd0; v.e_rd1 = rd1;
      v.e_owner = own; v.e_to = to; v.e_pe = pe;
      return v;
   endfunction

   task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      reset     = v.rst;
      p0_valid  = v.v0;
      p1_valid  = v.v1;
      mem_ready = v.rdy;
      mem_rdata = v.rdata;
   endtask

   task automatic checkOutput(input int idx, input vec_t v);
      logic [31:0] exp_wdata;
      logic        exp_instr;
      exp_wdata = (v.e_owner == 2'd1) ? P0_WDATA : (v.e_owner == 2'd2) ? P1_WDATA : 32'd0;
      exp_instr = (v.e_owner == 2'd1);
      expectEq($sformatf("v%0d mem_valid", idx), 32'(mem_valid), 32'(v.e_mvalid));
      expectEq($sformatf("v%0d mem_addr", idx), mem_addr, v.e_maddr);
      expectEq($sformatf("v%0d mem_wstrb", idx), 32'(mem_wstrb), 32'(v.e_mwstrb));
      expectEq($sformatf("v%0d mem_wdata", idx), mem_wdata, exp_wdata);
      expectEq($sformatf("v%0d mem_instr", idx), 32'(mem_instr), 32'(exp_instr));
      expectEq($sformatf("v%0d p0_ready", idx), 32'(p0_ready), 32'(v.e_r0));
      expectEq($sformatf("v%0d p1_ready", idx), 32'(p1_ready), 32'(v.e_r1));
      expectEq($sformatf("v%0d p0_rdata", idx), p0_rdata, v.e_rd0);
      expectEq($sformatf("v%0d p1_rdata", idx), p1_rdata, v.e_rd1);
      expectEq($sformatf("v%0d owner", idx), 32'(owner), 32'(v.e_owner));
      expectEq($sformatf("v%0d timeout", idx), 32'(timeout), 32'(v.e_to));
      expectEq($sformatf("v%0d proto_err", idx), 32'(proto_err), 32'(v.e_pe));
   endtask

   initial begin
      int fx_p0_cnt, fx_p1_cnt, rr_p0_cnt, rr_p1_cnt;

      reset = 1'b1; p0_valid = 1'b0; p1_valid = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0;
      p0_instr = 1'b1; p0_addr = P0_ADDR; p0_wdata = P0_WDATA; p0_wstrb = P0_WSTRB;
      p1_instr = 1'b0; p1_addr = P1_ADDR; p1_wdata = P1_WDATA; p1_wstrb = P1_WSTRB;

      // Single p0 read: one cycle of arbitration, then completion and back to idle
      vecs.push_back(mk(1,0,0,0,32'h0,          0,32'h0,4'h0, 0,0,32'h0,32'h0, 0,0,0));
      vecs.push_back(mk(0,1,0,0,32'h0,          0,32'h0,4'h0, 0,0,32'h0,32'h0, 0,0,0));
      vecs.push_back(mk(0,1,0,1,32'hDEADBEEF,   1,P0_ADDR,4'h0, 1,0,32'hDEADBEEF,32'h0, 1,0,0));
      vecs.push_back(mk(0,0,0,0,32'h0,          0,32'h0,4'h0, 0,0,32'h0,32'h0, 0,0,0));
      // Continuous contention under round-robin: owner 1,0,2,0,1,0,2
      vecs.push_back(mk(1,0,0,0,32'h0,          0,32'h0,4'h0, 0,0,32'h0,32'h0, 0,0,0));
      vecs.push_back(mk(0,1,1,1,32'h11111111,   0,32'h0,4'h0, 0,0,32'h0,32'h0, 0,0,0));
      vecs.push_back(mk(0,1,1,1,32'h11111111,   1,P0_ADDR,4'h0, 1,0,32'h11111111,32'h0, 1,0,0));
      vecs.push_back(mk(0,1,1,1,32'h11111111,   0,32'h0,4'h0, 0,0,32'h0,32'h0, 0,0,0));
      vecs.push_back(mk(0,1,1,1,32'h22222222,   1,P1_ADDR,4'hF, 0,1,32'h0,32'h22222222, 2,0,0));
      vecs.push_back(mk(0,1,1,1,32'h22222222,   0,32'h0,4'h0, 0,0,32'h0,32'h0, 0,0,0));
      vecs.push_back(mk(0,1,1,1,32'h33333333,   1,P0_ADDR,4'h0, 1,0,32'h33333333,32'h0, 1,0,0));
      vecs.push_back(mk(0,1,1,1,32'h33333333,   0,32'h0,4'h0, 0,0,32'h0,32'h0, 0,0,0));
      vecs.push_back(mk(0,1,1,1,32'h44444444,   1,P1_ADDR,4'hF, 0,1,32'h0,32'h44444444, 2,0,0));
      vecs.push_back(mk(0,0,0,0,32'h0,          0,32'h0,4'h0, 0,0,32'h0,32'h0, 0,0,0));
      // p1 stalled six cycles with MAX_WAIT=4: timeout visible after the 4th stall edge
      vecs.push_back(mk(0,0,1,0,32'h0,          0,32'h0,4'h0, 0,0,32'h0,32'h0, 0,0,0));
      vecs.push_back(mk(0,0,1,0,32'h0,          1,P1_ADDR,4'hF, 0,0,32'h0,32'h0, 2,0,0));
      vecs.push_back(mk(0,0,1,0,32'h0,          1,P1_ADDR,4'hF, 0,0,32'h0,32'h0, 2,0,0));
      vecs.push_back(mk(0,0,1,0,32'h0,          1,P1_ADDR,4'hF, 0,0,32'h0,32'h0, 2,0,0));
      vecs.push_back(mk(0,0,1,0,32'h0,          1,P1_ADDR,4'hF, 0,0,32'h0,32'h0, 2,0,0));
      vecs.push_back(mk(0,0,1,0,32'h0,          1,P1_ADDR,4'hF, 0,0,32'h0,32'h0, 2,1,0));
      vecs.push_back(mk(0,0,1,0,32'h0,          1,P1_ADDR,4'hF, 0,0,32'h0,32'h0, 2,1,0));
      vecs.push_back(mk(0,0,1,1,32'hCAFEF00D,   1,P1_ADDR,4'hF, 0,1,32'h0,32'hCAFEF00D, 2,1,0));
      vecs.push_back(mk(0,0,0,0,32'h0,          0,32'h0,4'h0, 0,0,32'h0,32'h0, 0,1,0));
      // p1 write withdrawn before ready: no ready pulse, proto_err sticks
      vecs.push_back(mk(0,0,1,0,32'h0,          0,32'h0,4'h0, 0,0,32'h0,32'h0, 0,1,0));
      vecs.push_back(mk(0,0,1,0,32'h0,          1,P1_ADDR,4'hF, 0,0,32'h0,32'h0, 2,1,0));
      vecs.push_back(mk(0,0,0,1,32'h77777777,   0,P1_ADDR,4'hF, 0,0,32'h0,32'h77777777, 2,1,0));
      vecs.push_back(mk(0,0,0,0,32'h0,          0,32'h0,4'h0, 0,0,32'h0,32'h0, 0,1,1));
      // Reset during a stalled p0 transfer, then p0 wins the first contended grant
      vecs.push_back(mk(0,1,0,0,32'h0,          0,32'h0,4'h0, 0,0,32'h0,32'h0, 0,1,1));
      vecs.push_back(mk(0,1,0,0,32'h0,          1,P0_ADDR,4'h0, 0,0,32'h0,32'h0, 1,1,1));
      vecs.push_back(mk(1,1,0,1,32'h99999999,   0,32'h0,4'h0, 0,0,32'h0,32'h0, 0,0,0));
      vecs.push_back(mk(0,1,1,0,32'h0,          0,32'h0,4'h0, 0,0,32'h0,32'h0, 0,0,0));
      vecs.push_back(mk(0,1,1,1,32'h5A5A5A5A,   1,P0_ADDR,4'h0, 1,0,32'h5A5A5A5A,32'h0, 1,0,0));
      vecs.push_back(mk(0,0,0,0,32'h0,          0,32'h0,4'h0, 0,0,32'h0,32'h0, 0,0,0));

      foreach (vecs[i]) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput(i, vecs[i]);
      end

      // Fixed priority vs round-robin under eight cycles of constant contention
      @(negedge clk);
      reset = 1'b1; p0_valid = 1'b0; p1_valid = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0;
      fx_p0_cnt = 0; fx_p1_cnt = 0; rr_p0_cnt = 0; rr_p1_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         reset = 1'b0; p0_valid = 1'b1; p1_valid = 1'b1; mem_ready = 1'b1;
         mem_rdata = 32'h0BAD_F00D;
         #1;
         expectEq($sformatf("fixed c%0d owner is not p1", c), 32'(fx_owner == 2'd2), 32'd0);
         fx_p0_cnt += int'(fx_p0_ready);
         fx_p1_cnt += int'(fx_p1_ready);
         rr_p0_cnt += int'(p0_ready);
         rr_p1_cnt += int'(p1_ready);
      end
      expectEq("fixed p0 grants", 32'(fx_p0_cnt), 32'd4);
      expectEq("fixed p1 grants", 32'(fx_p1_cnt), 32'd0);
      expectEq("rr p0 grants", 32'(rr_p0_cnt), 32'd2);
      expectEq("rr p1 grants", 32'(rr_p1_cnt), 32'd2);

      @(negedge clk);
      p0_valid = 1'b0; p1_valid = 1'b0; mem_ready = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
